mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage between EX and WB in the RV32I core.
- Consumes the EX pipeline registers and runs loads and stores on a req/ack data-memory bus.
- Handles byte-lane alignment, load sign/zero extension and a bus timeout.
- Registers results into the MEM/WB pipeline register, whose data also feeds the EX forwarding path. Raises MEM_Stall while a bus access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16, cycles spent in WAIT without ack before the access is abandoned; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- Clk  in  1  clock; all flops rise-edge.
- Reset_n  in  1  asynchronous, active-low reset.
- EX_Mem_wr_en  in  1  store request.
- EX_Mem_rd_en  in  1  load request.
- EX_Mem_op  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- EX_Rs2_data  in  32  store data.
- EX_MemToReg  in  1  writeback selects load data.
- EX_ALU_result  in  32  effective address or ALU result.
- EX_RegFile_wr_en  in  1  register write enable.
- EX_Rd_addr  in  5  destination register.
- DMem_req  out  1  bus request.
- DMem_we  out  1  1 = write.
- DMem_addr  out  32  word address {EX_ALU_result[31:2],2'b00}.
- DMem_be  out  4  byte enables.
- DMem_wdata  out  32  lane-replicated store data.
- DMem_ack  in  1  access complete; DMem_rdata valid on loads.
- DMem_rdata  in  32  read word.
- MEM_Stall  out  1  freezes PC/IF/ID/EX registers.
- MEM_RegFile_wr_en  out  1  WB write enable.
- MEM_Rd_addr  out  5  WB destination register.
- MEM_Rd_data  out  32  WB data.
- MEM_Access_err  out  1  one-cycle pulse: misaligned access or rd+wr conflict.
- MEM_Timeout  out  1  one-cycle pulse: bus timeout.

Behaviour:
- Access = EX_Mem_rd_en | EX_Mem_wr_en.
- Illegal access:
  - Both enables set.
  - W with addr[1:0] != 0.
  - H/HU with addr[0] = 1.
  - Unknown Mem_op while either enable is set.
  - Response: no DMem_req, no stall. Next edge registers a bubble (MEM_RegFile_wr_en=0) and MEM_Access_err=1 for one cycle.
- FSM states: IDLE, WAIT.
  - IDLE, legal access: DMem_req=1 combinationally that cycle.
    - DMem_ack same cycle: complete, no stall.
    - Else MEM_Stall=1 and go to WAIT; counter=1.
  - WAIT: DMem_req held; address, data, be and we held stable (EX regs are frozen by the stall). MEM_Stall = ~DMem_ack.
    - On ack: complete, go to IDLE. Stall drops the same cycle, so the pipeline advances on that edge with no re-issue.
    - If TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES without ack: drop DMem_req, MEM_Stall=0 that cycle, register a bubble, pulse MEM_Timeout, go to IDLE.
  - DMem_ack while DMem_req=0 is ignored.
- Store lanes:
  - SB: wdata = {4{rs2[7:0]}}, be = 4'b0001 << addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - SW: wdata = rs2, be = 4'b1111.
  - Loads: be = 4'b1111, we = 0.
- Load extract:
  - Byte selected by addr[1:0], halfword by addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes the word through.
- MEM/WB register, updated every edge:
  - While MEM_Stall=1: captures a bubble (wr_en=0, addr=0, data=0).
  - Otherwise: wr_en = EX_RegFile_wr_en, Rd_addr = EX_Rd_addr.
  - Rd_data = extracted load data if EX_MemToReg, else EX_ALU_result.
  - Stores with EX_RegFile_wr_en=1 still write ALU_result; the decoder does not generate that combination.
- Reset:
  - All registered outputs 0, state IDLE, counter 0.
  - Reset asserted mid-WAIT forces DMem_req=0 and MEM_Stall=0 immediately (asynchronous). A late ack after reset is ignored.
- Counter saturates and clears on entry to IDLE.

Test Plan:
- LB, addr 0x103, ack same cycle, rdata 0x80FF_1234 -> no stall; next cycle MEM_Rd_data=0xFFFF_FF80, wr_en=1.
- SH, addr 0x202, rs2 0x0000_ABCD, ack after 3 cycles -> MEM_Stall high 3 cycles; DMem_be=1100, DMem_wdata=0xABCD_ABCD, we=1; the bubble cycles show wr_en=0.
- LW, addr 0x0000_0006 -> no DMem_req; MEM_Access_err pulse; MEM_RegFile_wr_en=0. Repeat with rd_en and wr_en both set -> same response.
- TIMEOUT_CYCLES=4, LW with no ack -> req high for 4 cycles then low, MEM_Timeout one-cycle pulse, stall released, bubble written.
- ALU op with no access, ALU_result=0x1234_5678, MemToReg=0 -> next cycle MEM_Rd_data=0x1234_5678, no DMem_req.
- Reset_n low in WAIT -> DMem_req and MEM_Stall low immediately; outputs 0; an ack arriving after reset changes nothing.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage between EX and WB.
// Issues loads/stores on a req/ack bus, aligns byte lanes, extends load data,
// abandons accesses that exceed the timeout, and registers the MEM/WB result.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        EX_Mem_wr_en,
  input  logic        EX_Mem_rd_en,
  input  logic [2:0]  EX_Mem_op,
  input  logic [31:0] EX_Rs2_data,
  input  logic        EX_MemToReg,
  input  logic [31:0] EX_ALU_result,
  input  logic        EX_RegFile_wr_en,
  input  logic [4:0]  EX_Rd_addr,
  output logic        DMem_req,
  output logic        DMem_we,
  output logic [31:0] DMem_addr,
  output logic [3:0]  DMem_be,
  output logic [31:0] DMem_wdata,
  input  logic        DMem_ack,
  input  logic [31:0] DMem_rdata,
  output logic        MEM_Stall,
  output logic        MEM_RegFile_wr_en,
  output logic [4:0]  MEM_Rd_addr,
  output logic [31:0] MEM_Rd_data,
  output logic        MEM_Access_err,
  output logic        MEM_Timeout
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic        access, op_ok, misaligned, illegal, legal;
  logic        timeout_hit, req_int;
  logic [1:0]  lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  assign lane   = EX_ALU_result[1:0];
  assign access = EX_Mem_rd_en | EX_Mem_wr_en;

  // Access legality: known funct3, natural alignment, not both directions at once.
  always_comb begin
    op_ok      = 1'b0;
    misaligned = 1'b0;
    case (EX_Mem_op)
      3'b000, 3'b100: op_ok = 1'b1;
      3'b001, 3'b101: begin op_ok = 1'b1; misaligned = lane[0]; end
      3'b010:         begin op_ok = 1'b1; misaligned = (lane != 2'b00); end
      default:        op_ok = 1'b0;
    endcase
    illegal = (EX_Mem_rd_en & EX_Mem_wr_en) | (access & (~op_ok | misaligned));
    legal   = access & ~illegal;
  end

  // Bus handshake; reset gates req/stall immediately so a held EX access cannot re-issue.
  always_comb begin
    timeout_hit = (TIMEOUT_CYCLES != 0) && (state == S_WAIT) && (cnt == TO_CNT);
    req_int     = Reset_n & (((state == S_IDLE) & legal) | ((state == S_WAIT) & ~timeout_hit));
    DMem_req    = req_int;
    MEM_Stall   = req_int & ~DMem_ack;
    DMem_we     = req_int & EX_Mem_wr_en;
    DMem_addr   = {EX_ALU_result[31:2], 2'b00};
  end

  // Store lane replication and byte enables; loads read the full word.
  always_comb begin
    DMem_be    = 4'b1111;
    DMem_wdata = EX_Rs2_data;
    if (EX_Mem_wr_en) begin
      case (EX_Mem_op[1:0])
        2'b00: begin
          DMem_be    = 4'b0001 << lane;
          DMem_wdata = {4{EX_Rs2_data[7:0]}};
        end
        2'b01: begin
          DMem_be    = lane[1] ? 4'b1100 : 4'b0011;
          DMem_wdata = {2{EX_Rs2_data[15:0]}};
        end
        default: begin
          DMem_be    = 4'b1111;
          DMem_wdata = EX_Rs2_data;
        end
      endcase
    end
  end

  // Load extraction with sign or zero extension.
  always_comb begin
    ld_byte = DMem_rdata[7:0];
    case (lane)
      2'b01:   ld_byte = DMem_rdata[15:8];
      2'b10:   ld_byte = DMem_rdata[23:16];
      2'b11:   ld_byte = DMem_rdata[31:24];
      default: ld_byte = DMem_rdata[7:0];
    endcase
    ld_half = lane[1] ? DMem_rdata[31:16] : DMem_rdata[15:0];
    case (EX_Mem_op)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = DMem_rdata;
    endcase
  end

  // IDLE/WAIT sequencing with a saturating wait counter cleared on return to IDLE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (legal && !DMem_ack) begin
            state <= S_WAIT;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        default: begin
          if (timeout_hit || DMem_ack) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // MEM/WB register: bubble while stalled, on an illegal access or on a timeout.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      MEM_RegFile_wr_en <= 1'b0;
      MEM_Rd_addr       <= '0;
      MEM_Rd_data       <= '0;
      MEM_Access_err    <= 1'b0;
      MEM_Timeout       <= 1'b0;
    end else begin
      MEM_Access_err <= illegal & (state == S_IDLE);
      MEM_Timeout    <= timeout_hit;
      if (MEM_Stall || illegal || timeout_hit) begin
        MEM_RegFile_wr_en <= 1'b0;
        MEM_Rd_addr       <= '0;
        MEM_Rd_data       <= '0;
      end else begin
        MEM_RegFile_wr_en <= EX_RegFile_wr_en;
        MEM_Rd_addr       <= EX_Rd_addr;
        MEM_Rd_data       <= EX_MemToReg ? load_data : EX_ALU_result;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a MEM/WB scoreboard queue.
module tb_mem_stage;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        EX_Mem_wr_en, EX_Mem_rd_en, EX_MemToReg, EX_RegFile_wr_en;
  logic [2:0]  EX_Mem_op;
  logic [31:0] EX_Rs2_data, EX_ALU_result;
  logic [4:0]  EX_Rd_addr;
  logic        DMem_req, DMem_we, DMem_ack;
  logic [31:0] DMem_addr, DMem_wdata, DMem_rdata;
  logic [3:0]  DMem_be;
  logic        MEM_Stall, MEM_RegFile_wr_en, MEM_Access_err, MEM_Timeout;
  logic [4:0]  MEM_Rd_addr;
  logic [31:0] MEM_Rd_data;

  typedef struct packed {
    logic        wr_en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    logic        tmo;
  } wb_t;

  wb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  mem_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .EX_Mem_wr_en(EX_Mem_wr_en), .EX_Mem_rd_en(EX_Mem_rd_en), .EX_Mem_op(EX_Mem_op),
    .EX_Rs2_data(EX_Rs2_data), .EX_MemToReg(EX_MemToReg), .EX_ALU_result(EX_ALU_result),
    .EX_RegFile_wr_en(EX_RegFile_wr_en), .EX_Rd_addr(EX_Rd_addr),
    .DMem_req(DMem_req), .DMem_we(DMem_we), .DMem_addr(DMem_addr), .DMem_be(DMem_be),
    .DMem_wdata(DMem_wdata), .DMem_ack(DMem_ack), .DMem_rdata(DMem_rdata),
    .MEM_Stall(MEM_Stall), .MEM_RegFile_wr_en(MEM_RegFile_wr_en), .MEM_Rd_addr(MEM_Rd_addr),
    .MEM_Rd_data(MEM_Rd_data), .MEM_Access_err(MEM_Access_err), .MEM_Timeout(MEM_Timeout)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic wr_en, input logic [4:0] rd, input logic [31:0] data,
                      input logic err, input logic tmo);
    wb_t e;
    e.wr_en = wr_en; e.rd = rd; e.data = data; e.err = err; e.tmo = tmo;
    sb_q.push_back(e);
  endtask

  // Advance one edge, then compare the registered MEM/WB outputs against the oldest expectation.
  task automatic tick_check(input string tag);
    wb_t e;
    @(posedge Clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_scoreboard: observed empty queue expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_wr_en"}, 32'(MEM_RegFile_wr_en), 32'(e.wr_en));
      chk({tag, "_rd"},    32'(MEM_Rd_addr),       32'(e.rd));
      chk({tag, "_data"},  MEM_Rd_data,            e.data);
      chk({tag, "_err"},   32'(MEM_Access_err),    32'(e.err));
      chk({tag, "_tmo"},   32'(MEM_Timeout),       32'(e.tmo));
    end
  endtask

  task automatic drive(input logic rd_en, input logic wr_en, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] rs2, input logic m2r,
                       input logic rf_we, input logic [4:0] rd);
    EX_Mem_rd_en = rd_en; EX_Mem_wr_en = wr_en; EX_Mem_op = op; EX_ALU_result = addr;
    EX_Rs2_data = rs2; EX_MemToReg = m2r; EX_RegFile_wr_en = rf_we; EX_Rd_addr = rd;
    #1;
  endtask

  initial begin
    Reset_n = 1'b0;
    DMem_ack = 1'b0; DMem_rdata = 32'h80FF_1234;
    drive(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 5'd0);
    #12;
    chk("rst_req",   32'(DMem_req),          32'd0);
    chk("rst_stall", 32'(MEM_Stall),         32'd0);
    chk("rst_wr_en", 32'(MEM_RegFile_wr_en), 32'd0);
    chk("rst_data",  MEM_Rd_data,            32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    // LB at 0x103, ack in the issue cycle
    DMem_ack = 1'b1;
    drive(1, 0, 3'b000, 32'h103, 32'h0, 1, 1, 5'd5);
    chk("lb_req", 32'(DMem_req), 32'd1);
    chk("lb_stall", 32'(MEM_Stall), 32'd0);
    chk("lb_we", 32'(DMem_we), 32'd0);
    chk("lb_be", 32'(DMem_be), 32'hF);
    chk("lb_addr", DMem_addr, 32'h100);
    push(1, 5'd5, 32'hFFFF_FF80, 0, 0);
    tick_check("lb");

    // Further load extraction cases, all acked immediately
    drive(1, 0, 3'b101, 32'h302, 32'h0, 1, 1, 5'd6);
    push(1, 5'd6, 32'h0000_80FF, 0, 0);
    tick_check("lhu");
    drive(1, 0, 3'b001, 32'h302, 32'h0, 1, 1, 5'd6);
    push(1, 5'd6, 32'hFFFF_80FF, 0, 0);
    tick_check("lh");
    drive(1, 0, 3'b100, 32'h101, 32'h0, 1, 1, 5'd8);
    push(1, 5'd8, 32'h0000_0012, 0, 0);
    tick_check("lbu");
    drive(1, 0, 3'b010, 32'h100, 32'h0, 1, 1, 5'd9);
    push(1, 5'd9, 32'h80FF_1234, 0, 0);
    tick_check("lw");

    // SB and SW lane checks
    drive(0, 1, 3'b000, 32'h101, 32'h0000_0055, 0, 0, 5'd0);
    chk("sb_be", 32'(DMem_be), 32'b0010);
    chk("sb_wdata", DMem_wdata, 32'h5555_5555);
    chk("sb_we", 32'(DMem_we), 32'd1);
    push(0, 5'd0, 32'h101, 0, 0);
    tick_check("sb");
    drive(0, 1, 3'b010, 32'h104, 32'hDEAD_BEEF, 0, 0, 5'd0);
    chk("sw_be", 32'(DMem_be), 32'hF);
    chk("sw_wdata", DMem_wdata, 32'hDEAD_BEEF);
    push(0, 5'd0, 32'h104, 0, 0);
    tick_check("sw");

    // ALU pass-through, no access; a stray ack must not matter
    drive(0, 0, 3'b000, 32'h1234_5678, 32'h0, 0, 1, 5'd7);
    chk("alu_req", 32'(DMem_req), 32'd0);
    push(1, 5'd7, 32'h1234_5678, 0, 0);
    tick_check("alu");

    // SH at 0x202 acked after three stalled cycles
    DMem_ack = 1'b0;
    drive(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 0, 0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      chk("sh_req", 32'(DMem_req), 32'd1);
      chk("sh_stall", 32'(MEM_Stall), 32'd1);
      chk("sh_be", 32'(DMem_be), 32'b1100);
      chk("sh_wdata", DMem_wdata, 32'hABCD_ABCD);
      chk("sh_we", 32'(DMem_we), 32'd1);
      chk("sh_addr", DMem_addr, 32'h200);
      push(0, 5'd0, 32'd0, 0, 0);
      tick_check("sh_bubble");
    end
    DMem_ack = 1'b1; #1;
    chk("sh_ack_stall", 32'(MEM_Stall), 32'd0);
    chk("sh_ack_req", 32'(DMem_req), 32'd1);
    push(0, 5'd0, 32'h202, 0, 0);
    tick_check("sh_done");
    DMem_ack = 1'b0;

    // Illegal accesses: misaligned LW, rd+wr conflict, unknown funct3
    drive(1, 0, 3'b010, 32'h6, 32'h0, 1, 1, 5'd3);
    chk("mis_req", 32'(DMem_req), 32'd0);
    chk("mis_stall", 32'(MEM_Stall), 32'd0);
    push(0, 5'd0, 32'd0, 1, 0);
    tick_check("mis");
    drive(1, 1, 3'b010, 32'h100, 32'h0, 1, 1, 5'd3);
    chk("both_req", 32'(DMem_req), 32'd0);
    push(0, 5'd0, 32'd0, 1, 0);
    tick_check("both");
    drive(1, 0, 3'b011, 32'h100, 32'h0, 1, 1, 5'd3);
    chk("badop_req", 32'(DMem_req), 32'd0);
    push(0, 5'd0, 32'd0, 1, 0);
    tick_check("badop");
    drive(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 5'd0);
    push(0, 5'd0, 32'd0, 0, 0);
    tick_check("err_clear");

    // Timeout with TIMEOUT_CYCLES=4: req high four cycles, then dropped
    drive(1, 0, 3'b010, 32'h400, 32'h0, 1, 1, 5'd9);
    for (int i = 0; i < 4; i++) begin
      chk("to_req", 32'(DMem_req), 32'd1);
      chk("to_stall", 32'(MEM_Stall), 32'd1);
      push(0, 5'd0, 32'd0, 0, 0);
      tick_check("to_bubble");
    end
    chk("to_req_drop", 32'(DMem_req), 32'd0);
    chk("to_stall_drop", 32'(MEM_Stall), 32'd0);
    push(0, 5'd0, 32'd0, 0, 1);
    tick_check("to_fire");
    drive(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 5'd0);
    push(0, 5'd0, 32'd0, 0, 0);
    tick_check("to_clear");

    // Reset asserted mid-WAIT, followed by a late ack
    drive(1, 0, 3'b010, 32'h500, 32'h0, 1, 1, 5'd4);
    push(0, 5'd0, 32'd0, 0, 0);
    tick_check("rw_bubble0");
    push(0, 5'd0, 32'd0, 0, 0);
    tick_check("rw_bubble1");
    #2;
    chk("rw_pre_req", 32'(DMem_req), 32'd1);
    Reset_n = 1'b0; #1;
    chk("rw_req", 32'(DMem_req), 32'd0);
    chk("rw_stall", 32'(MEM_Stall), 32'd0);
    chk("rw_wr_en", 32'(MEM_RegFile_wr_en), 32'd0);
    chk("rw_timeout", 32'(MEM_Timeout), 32'd0);
    drive(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 5'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    DMem_ack = 1'b1; #1;
    chk("late_ack_req", 32'(DMem_req), 32'd0);
    chk("late_ack_stall", 32'(MEM_Stall), 32'd0);
    push(0, 5'd0, 32'd0, 0, 0);
    tick_check("late_ack");
    DMem_ack = 1'b0;

    // After the late ack the FSM must be back in IDLE: a fresh load stalls from cnt 1
    drive(1, 0, 3'b010, 32'h600, 32'h0, 1, 1, 5'd2);
    chk("post_rst_stall", 32'(MEM_Stall), 32'd1);
    push(0, 5'd0, 32'd0, 0, 0);
    tick_check("post_rst");
    DMem_rdata = 32'hCAFE_F00D;
    DMem_ack = 1'b1; #1;
    push(1, 5'd2, 32'hCAFE_F00D, 0, 0);
    tick_check("post_rst_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
